// File: rtl/video_timing_pkg.sv
// Shared timing constants for the 15 kHz arcade raster generator.
// Default values describe the standard arcade mode; widths are shared by all files.
package video_timing_pkg;

    localparam int CNT_W = 9;
    localparam int CMP_W = 10;
    localparam int RGB_W = 6;

    localparam int DEFAULT_H_TOTAL      = 384;
    localparam int DEFAULT_H_ACTIVE     = 256;
    localparam int DEFAULT_H_SYNC_START = 288;
    localparam int DEFAULT_H_SYNC_LEN   = 32;

    localparam int DEFAULT_V_TOTAL      = 264;
    localparam int DEFAULT_V_ACTIVE     = 224;
    localparam int DEFAULT_V_SYNC_START = 240;
    localparam int DEFAULT_V_SYNC_LEN   = 3;

    // Lowest hsync start that keeps sync out of the scandoubler's line-length window.
    localparam int MIN_H_SYNC_START = 128;

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: a wrapping position counter plus blank/sync decodes of the
// current position, used once for pixels within a line and once for lines.
module video_axis_counter
    import video_timing_pkg::*;
#(
    parameter int TOTAL      = DEFAULT_H_TOTAL,
    parameter int ACTIVE     = DEFAULT_H_ACTIVE,
    parameter int SYNC_START = DEFAULT_H_SYNC_START,
    parameter int SYNC_LEN   = DEFAULT_H_SYNC_LEN
) (
    input  logic             clkvideo,
    input  logic             rst_n,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             blank_next,
    output logic             sync_next
);

    generate
        if (!((ACTIVE <= SYNC_START) && (SYNC_START + SYNC_LEN <= TOTAL) &&
              (TOTAL <= 512) && (SYNC_LEN >= 1) && (ACTIVE >= 1))) begin : g_bad_axis_params
            $error("video_axis_counter: inconsistent axis timing parameters");
        end
    endgenerate

    localparam logic [CMP_W-1:0] L_LAST       = CMP_W'(TOTAL - 1);
    localparam logic [CMP_W-1:0] L_ACTIVE     = CMP_W'(ACTIVE);
    localparam logic [CMP_W-1:0] L_SYNC_START = CMP_W'(SYNC_START);
    localparam logic [CMP_W-1:0] L_SYNC_END   = CMP_W'(SYNC_START + SYNC_LEN);

    logic [CNT_W-1:0] r_count;
    logic [CMP_W-1:0] w_count_ext;

    // Compare in one extra bit so SYNC_START+SYNC_LEN == TOTAL cannot overflow.
    assign w_count_ext = {1'b0, r_count};
    assign wrap        = (w_count_ext == L_LAST);
    assign blank_next  = (w_count_ext >= L_ACTIVE);
    assign sync_next   = (w_count_ext >= L_SYNC_START) && (w_count_ext < L_SYNC_END);
    assign count       = r_count;

    // Position counter: wraps to zero after the last position of the axis.
    always_ff @(posedge clkvideo or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (advance) begin
            r_count <= wrap ? {CNT_W{1'b0}} : (r_count + CNT_W'(1));
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/video_sync_gen.sv
// Raster timing generator: pixel coordinates for the core, and a one-pixel-delayed
// output stage with blanked RGB, separate syncs and serrated composite sync.
module video_sync_gen
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL      = DEFAULT_H_TOTAL,
    parameter int H_ACTIVE     = DEFAULT_H_ACTIVE,
    parameter int H_SYNC_START = DEFAULT_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEFAULT_H_SYNC_LEN,
    parameter int V_TOTAL      = DEFAULT_V_TOTAL,
    parameter int V_ACTIVE     = DEFAULT_V_ACTIVE,
    parameter int V_SYNC_START = DEFAULT_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEFAULT_V_SYNC_LEN
) (
    input  logic             clkvideo,
    input  logic             rst_n,
    input  logic             ce_pix,
    input  logic [RGB_W-1:0] ri_core,
    input  logic [RGB_W-1:0] gi_core,
    input  logic [RGB_W-1:0] bi_core,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblank,
    output logic             vblank,
    output logic [RGB_W-1:0] ro,
    output logic [RGB_W-1:0] go,
    output logic [RGB_W-1:0] bo,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             csync_n,
    output logic             frame_start
);

    generate
        if (H_SYNC_START < MIN_H_SYNC_START) begin : g_bad_hsync_position
            $error("video_sync_gen: H_SYNC_START too early for downstream line measurement");
        end
    endgenerate

    logic             w_h_wrap;
    logic             w_h_blank_next;
    logic             w_h_sync_next;
    logic             w_v_wrap;
    logic             w_v_blank_next;
    logic             w_v_sync_next;
    logic             w_v_advance;
    logic             w_blank;
    logic [RGB_W-1:0] w_ro_next;
    logic [RGB_W-1:0] w_go_next;
    logic [RGB_W-1:0] w_bo_next;

    logic             r_hblank;
    logic             r_vblank;
    logic [RGB_W-1:0] r_ro;
    logic [RGB_W-1:0] r_go;
    logic [RGB_W-1:0] r_bo;
    logic             r_hsync_n;
    logic             r_vsync_n;
    logic             r_csync_n;
    logic             r_frame_start;

    assign w_v_advance = ce_pix & w_h_wrap;

    video_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SYNC_START),
        .SYNC_LEN   (H_SYNC_LEN)
    ) u_h_axis (
        .clkvideo   (clkvideo),
        .rst_n      (rst_n),
        .advance    (ce_pix),
        .count      (hcount),
        .wrap       (w_h_wrap),
        .blank_next (w_h_blank_next),
        .sync_next  (w_h_sync_next)
    );

    video_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SYNC_START),
        .SYNC_LEN   (V_SYNC_LEN)
    ) u_v_axis (
        .clkvideo   (clkvideo),
        .rst_n      (rst_n),
        .advance    (w_v_advance),
        .count      (vcount),
        .wrap       (w_v_wrap),
        .blank_next (w_v_blank_next),
        .sync_next  (w_v_sync_next)
    );

    // Blank the core colour outside the visible window.
    always_comb begin
        w_blank   = w_h_blank_next | w_v_blank_next;
        w_ro_next = ri_core;
        w_go_next = gi_core;
        w_bo_next = bi_core;
        if (w_blank) begin
            w_ro_next = {RGB_W{1'b0}};
            w_go_next = {RGB_W{1'b0}};
            w_bo_next = {RGB_W{1'b0}};
        end else begin
            w_ro_next = ri_core;
            w_go_next = gi_core;
            w_bo_next = bi_core;
        end
    end

    // Output stage: csync_n = hsync_n XNOR vsync_n, which inverts hsync during vsync lines.
    always_ff @(posedge clkvideo or negedge rst_n) begin
        if (!rst_n) begin
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_ro          <= {RGB_W{1'b0}};
            r_go          <= {RGB_W{1'b0}};
            r_bo          <= {RGB_W{1'b0}};
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_csync_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (ce_pix) begin
            r_hblank      <= w_h_blank_next;
            r_vblank      <= w_v_blank_next;
            r_ro          <= w_ro_next;
            r_go          <= w_go_next;
            r_bo          <= w_bo_next;
            r_hsync_n     <= ~w_h_sync_next;
            r_vsync_n     <= ~w_v_sync_next;
            r_csync_n     <= ~(w_h_sync_next ^ w_v_sync_next);
            r_frame_start <= w_h_wrap & w_v_wrap;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign ro          = r_ro;
    assign go          = r_go;
    assign bo          = r_bo;
    assign hsync_n     = r_hsync_n;
    assign vsync_n     = r_vsync_n;
    assign csync_n     = r_csync_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_sync_gen.sv
// Self-checking bench: a default-timing instance and a short-frame instance share
// stimulus; a counting reference model predicts every output each cycle.
module tb_video_sync_gen;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic       hb;
        logic       vb;
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
        logic       hs;
        logic       vs;
        logic       cs;
        logic       fs;
    } obs_t;

    typedef struct {
        int         n;
        logic [8:0] h;
        logic [8:0] v;
        logic       hb;
        logic       vb;
        logic [5:0] ro;
        logic       hs;
        logic       cs;
    } vec_t;

    localparam int S_VT = 20, S_VA = 12, S_VSS = 14, S_VSL = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic [5:0] ri, gi, bi;

    logic [8:0] d0_h, d0_v, d1_h, d1_v;
    logic       d0_hb, d0_vb, d0_hs, d0_vs, d0_cs, d0_fs;
    logic       d1_hb, d1_vb, d1_hs, d1_vs, d1_cs, d1_fs;
    logic [5:0] d0_r, d0_g, d0_b, d1_r, d1_g, d1_b;
    obs_t       act0, act1, e0, e1;
    obs_t       rst_obs;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    video_sync_gen u_dut0 (
        .clkvideo(clk), .rst_n(rst_n), .ce_pix(ce),
        .ri_core(ri), .gi_core(gi), .bi_core(bi),
        .hcount(d0_h), .vcount(d0_v), .hblank(d0_hb), .vblank(d0_vb),
        .ro(d0_r), .go(d0_g), .bo(d0_b),
        .hsync_n(d0_hs), .vsync_n(d0_vs), .csync_n(d0_cs), .frame_start(d0_fs)
    );

    video_sync_gen #(
        .V_TOTAL(S_VT), .V_ACTIVE(S_VA), .V_SYNC_START(S_VSS), .V_SYNC_LEN(S_VSL)
    ) u_dut1 (
        .clkvideo(clk), .rst_n(rst_n), .ce_pix(ce),
        .ri_core(ri), .gi_core(gi), .bi_core(bi),
        .hcount(d1_h), .vcount(d1_v), .hblank(d1_hb), .vblank(d1_vb),
        .ro(d1_r), .go(d1_g), .bo(d1_b),
        .hsync_n(d1_hs), .vsync_n(d1_vs), .csync_n(d1_cs), .frame_start(d1_fs)
    );

    assign act0 = {d0_h, d0_v, d0_hb, d0_vb, d0_r, d0_g, d0_b, d0_hs, d0_vs, d0_cs, d0_fs};
    assign act1 = {d1_h, d1_v, d1_hb, d1_vb, d1_r, d1_g, d1_b, d1_hs, d1_vs, d1_cs, d1_fs};

    // Reference: after n pixel-enables the raster position is n mod (HT) along the line and
    // (n div HT) mod VT down the frame; outputs describe the position one enable earlier.
    function automatic obs_t model_step(obs_t cur, int cnt, bit en, logic [5:0] r, logic [5:0] g,
                                        logic [5:0] b, int vt, int va, int vss, int vsl);
        obs_t nx;
        int   h, v;
        bit   hbk, vbk, hsy, vsy;
        nx = cur;
        if (!en) begin
            nx.fs = 1'b0;
            return nx;
        end
        h   = cnt % 384;
        v   = (cnt / 384) % vt;
        hbk = (h >= 256);
        vbk = (v >= va);
        hsy = (h >= 288) && (h < 288 + 32);
        vsy = (v >= vss) && (v < vss + vsl);
        nx.hb = hbk;
        nx.vb = vbk;
        nx.r  = (hbk || vbk) ? 6'd0 : r;
        nx.g  = (hbk || vbk) ? 6'd0 : g;
        nx.b  = (hbk || vbk) ? 6'd0 : b;
        nx.hs = !hsy;
        nx.vs = !vsy;
        nx.cs = (hsy == vsy);
        nx.h  = 9'((cnt + 1) % 384);
        nx.v  = 9'(((cnt + 1) / 384) % vt);
        nx.fs = (((cnt + 1) % (384 * vt)) == 0);
        return nx;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d act=%h exp=%h", name, n, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, let the edge happen, advance the models, compare at negedge.
    task automatic cyc(input bit en, input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        ce = en; ri = r; gi = g; bi = b;
        @(posedge clk);
        e0 = model_step(e0, n, en, r, g, b, 264, 224, 240, 3);
        e1 = model_step(e1, n, en, r, g, b, S_VT, S_VA, S_VSS, S_VSL);
        if (en) n++;
        @(negedge clk);
        check_obs("model_default", act0, e0);
        check_obs("model_short", act1, e1);
    endtask

    task automatic cyc_rand(input bit en);
        cyc(en, 6'($urandom), 6'($urandom), 6'($urandom));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ce    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_obs("reset_default", act0, rst_obs);
        check_obs("reset_short", act1, rst_obs);
        rst_n = 1'b1;
        n  = 0;
        e0 = rst_obs;
        e1 = rst_obs;
    endtask

    vec_t vt[10];
    int   fs_cnt, fs_at, vs_low, wrap_clk0, wrap_clk1;
    logic [8:0] prev_v;

    initial begin
        rst_obs = '{h: 9'd0, v: 9'd0, hb: 1'b1, vb: 1'b1, r: 6'd0, g: 6'd0, b: 6'd0,
                    hs: 1'b1, vs: 1'b1, cs: 1'b1, fs: 1'b0};
        vt[0] = '{1,   9'd1,   9'd0, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b1};
        vt[1] = '{256, 9'd256, 9'd0, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b1};
        vt[2] = '{257, 9'd257, 9'd0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b1};
        vt[3] = '{288, 9'd288, 9'd0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b1};
        vt[4] = '{289, 9'd289, 9'd0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0};
        vt[5] = '{320, 9'd320, 9'd0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b0};
        vt[6] = '{321, 9'd321, 9'd0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b1};
        vt[7] = '{384, 9'd0,   9'd1, 1'b1, 1'b0, 6'h00, 1'b1, 1'b1};
        vt[8] = '{385, 9'd1,   9'd1, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b1};
        vt[9] = '{640, 9'd256, 9'd1, 1'b0, 1'b0, 6'h3F, 1'b1, 1'b1};

        rst_n = 1'b0; ce = 1'b0; ri = 6'd0; gi = 6'd0; bi = 6'd0; n = 0;
        e0 = rst_obs; e1 = rst_obs;
        repeat (2) @(posedge clk);
        @(negedge clk);
        do_reset();

        // Hand-computed line landmarks on the default instance with white input.
        for (int i = 0; i < 10; i++) begin
            while (n < vt[i].n) cyc(1'b1, 6'h3F, 6'h3F, 6'h3F);
            checks++;
            if ({d0_h, d0_v, d0_hb, d0_vb, d0_r, d0_hs, d0_cs} !==
                {vt[i].h, vt[i].v, vt[i].hb, vt[i].vb, vt[i].ro, vt[i].hs, vt[i].cs}) begin
                errors++;
                $display("FAIL vec%0d n=%0d act h=%0d v=%0d hb=%b vb=%b ro=%h hs=%b cs=%b exp h=%0d v=%0d hb=%b vb=%b ro=%h hs=%b cs=%b",
                         i, n, d0_h, d0_v, d0_hb, d0_vb, d0_r, d0_hs, d0_cs,
                         vt[i].h, vt[i].v, vt[i].hb, vt[i].vb, vt[i].ro, vt[i].hs, vt[i].cs);
            end
        end

        // Full short frame: one frame_start at 384*20 enables, vsync low 3 lines.
        do_reset();
        fs_cnt = 0; fs_at = -1; vs_low = 0;
        for (int i = 0; i < 384 * S_VT + 400; i++) begin
            cyc_rand(1'b1);
            if (d1_fs) begin
                fs_cnt++;
                fs_at = n;
            end
            if (!d1_vs) vs_low++;
        end
        check_int("frame_start_count", fs_cnt, 1);
        check_int("frame_start_at", fs_at, 384 * S_VT);
        check_int("vsync_low_len", vs_low, 3 * 384);

        // Random pixel enables and colours.
        for (int i = 0; i < 3000; i++) cyc_rand(1'($urandom_range(0, 1)));

        // Alternating enable: line period doubles to 768 clocks.
        do_reset();
        wrap_clk0 = -1; wrap_clk1 = -1;
        prev_v = d0_v;
        for (int i = 0; i < 1600; i++) begin
            cyc_rand(((i % 2) == 0));
            if (d0_v != prev_v) begin
                if (wrap_clk0 < 0) wrap_clk0 = i;
                else if (wrap_clk1 < 0) wrap_clk1 = i;
            end
            prev_v = d0_v;
        end
        check_int("toggle_first_wrap", wrap_clk0, 766);
        check_int("toggle_line_period", wrap_clk1 - wrap_clk0, 768);

        // Asynchronous reset in mid-clock at (300,15) of the short frame, inside vsync.
        do_reset();
        while (n < 15 * 384 + 300) cyc_rand(1'b1);
        check_int("pre_rst_h", int'(d1_h), 300);
        check_int("pre_rst_v", int'(d1_v), 15);
        #2;
        rst_n = 1'b0;
        #1;
        check_obs("async_rst_default", act0, rst_obs);
        check_obs("async_rst_short", act1, rst_obs);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0; e0 = rst_obs; e1 = rst_obs;
        cyc_rand(1'b1);
        check_int("restart_h", int'(d1_h), 1);
        check_int("restart_v", int'(d1_v), 0);
        repeat (20) cyc_rand(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
